// File: rtl/ram_burst_reader.sv
// Burst read engine for one-cycle-latency synchronous RAM.
// Issued words are returned on a valid/ready stream through a 2-entry skid FIFO.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBaseAddress,
    input  logic [CNT_WIDTH-1:0]  iCount,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oReadEnable,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    input  logic [DATA_WIDTH-1:0] iRamData,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oValid,
    input  logic                  iReady
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  in_flight_q, in_flight_d;
    logic [1:0]            buf_count_q, buf_count_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

    logic pop, wr, issue, drained;

    assign pop     = (buf_count_q != 2'd0) && iReady;
    assign wr      = in_flight_q;
    assign drained = !in_flight_q && (buf_count_q == 2'd0);
    // Occupancy after this cycle's pop must leave room for the word now being issued.
    assign issue   = (state_q == READ) && (remaining_q != '0) &&
                     (({1'b0, buf_count_q} + {2'b00, in_flight_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        in_flight_d = issue;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    addr_d      = iBaseAddress;
                    remaining_d = iCount;
                    state_d     = (iCount == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_count_d = buf_count_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        case ({wr, pop})
            2'b01: begin
                buf0_d      = buf1_q;
                buf_count_d = buf_count_q - 2'd1;
            end
            2'b10: begin
                if (buf_count_q == 2'd0) begin
                    buf0_d = iRamData;
                end else begin
                    buf1_d = iRamData;
                end
                buf_count_d = buf_count_q + 2'd1;
            end
            2'b11: begin
                if (buf_count_q == 2'd1) begin
                    buf0_d = iRamData;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = iRamData;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            in_flight_q <= 1'b0;
            buf_count_q <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            in_flight_q <= in_flight_d;
            buf_count_q <= buf_count_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

    assign oBusy        = (state_q != IDLE);
    assign oDone        = (state_q == DRAIN) && drained;
    assign oReadEnable  = issue;
    assign oReadAddress = addr_q;
    assign oData        = buf0_q;
    assign oValid       = (buf_count_q != 2'd0);

    a_no_overflow: assert property (@(posedge Clock) disable iff (Reset)
        !(wr && !pop && (buf_count_q == 2'd2)));
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: per-cycle vector table plus stall/reset/restart sequences.
module tb_ram_burst_reader;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic [15:0] iBaseAddress;
    logic [7:0]  iCount;
    logic        oBusy, oDone, oReadEnable, oValid, iReady;
    logic [15:0] oReadAddress;
    logic [31:0] iRamData, oData;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, written only by the monitor process.
    int          issued = 0;
    int          accepted = 0;
    int          dones = 0;
    logic [31:0] rx[$];

    typedef struct {
        int          test;
        logic        start;
        logic [15:0] base;
        logic [7:0]  count;
        logic        re;
        logic [15:0] addr;
        logic        valid;
        logic [31:0] data;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    ram_burst_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .CNT_WIDTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iBaseAddress(iBaseAddress),
        .iCount(iCount), .oBusy(oBusy), .oDone(oDone), .oReadEnable(oReadEnable),
        .oReadAddress(oReadAddress), .iRamData(iRamData), .oData(oData),
        .oValid(oValid), .iReady(iReady)
    );

    always #5 Clock = ~Clock;

    // RAM model: word at address a holds a; junk when no read was issued.
    always @(posedge Clock) begin
        if (oReadEnable) iRamData <= {16'h0000, oReadAddress};
        else             iRamData <= 32'hDEAD_BEEF;
    end

    always @(posedge Clock) begin
        if (Reset !== 1'b1) begin
            if (oReadEnable) issued = issued + 1;
            if (oValid && iReady) begin
                accepted = accepted + 1;
                rx.push_back(oData);
            end
            if (oDone) dones = dones + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(int t, logic s, logic [15:0] b, logic [7:0] n, logic re,
                                logic [15:0] a, logic v, logic [31:0] d, logic dn, logic bz);
        vec_t x;
        x.test = t; x.start = s; x.base = b; x.count = n; x.re = re; x.addr = a;
        x.valid = v; x.data = d; x.done = dn; x.busy = bz;
        vecs.push_back(x);
    endfunction

    task automatic run_burst(input string name, input logic [15:0] base, input logic [7:0] count,
                             input logic pulse);
        int   n0;
        int   d0;
        logic got;
        n0 = rx.size();
        d0 = dones;
        got = 1'b0;
        @(negedge Clock);
        iStart = 1'b1; iBaseAddress = base; iCount = count; iReady = 1'b1;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge Clock);
            iStart = pulse; iBaseAddress = ~base; iCount = 8'd3;
            #1;
            if (oDone) got = 1'b1;
        end
        iStart = 1'b0;
        check({name, "_done_seen"}, {31'd0, got}, 32'd1);
        @(negedge Clock);
        #1;
        check({name, "_done_count"}, dones - d0, 32'd1);
        check({name, "_word_count"}, rx.size() - n0, {24'd0, count});
        for (int i = 0; i < int'(count); i++) begin
            if (n0 + i < rx.size())
                check($sformatf("%s_word%0d", name, i), rx[n0 + i], {16'h0000, base + 16'(i)});
        end
        check({name, "_idle_after"}, {31'd0, oBusy}, 32'd0);
    endtask

    initial begin
        int d0;
        int a0;
        Reset = 1'b1; iStart = 1'b0; iBaseAddress = '0; iCount = '0; iReady = 1'b1;

        // T1: base 0x10, count 4
        add(1, 1, 16'h0010, 8'd4, 0, 16'h0000, 0, 32'h0,  0, 0);
        add(1, 0, 16'h0,    8'd0, 1, 16'h0010, 0, 32'h0,  0, 1);
        add(1, 0, 16'h0,    8'd0, 1, 16'h0011, 0, 32'h0,  0, 1);
        add(1, 0, 16'h0,    8'd0, 1, 16'h0012, 1, 32'h10, 0, 1);
        add(1, 0, 16'h0,    8'd0, 1, 16'h0013, 1, 32'h11, 0, 1);
        add(1, 0, 16'h0,    8'd0, 0, 16'h0000, 1, 32'h12, 0, 1);
        add(1, 0, 16'h0,    8'd0, 0, 16'h0000, 1, 32'h13, 0, 1);
        add(1, 0, 16'h0,    8'd0, 0, 16'h0000, 0, 32'h0,  1, 1);
        add(1, 0, 16'h0,    8'd0, 0, 16'h0000, 0, 32'h0,  0, 0);
        // T2: count 0
        add(2, 1, 16'h0077, 8'd0, 0, 16'h0000, 0, 32'h0,  0, 0);
        add(2, 0, 16'h0,    8'd0, 0, 16'h0000, 0, 32'h0,  1, 1);
        add(2, 0, 16'h0,    8'd0, 0, 16'h0000, 0, 32'h0,  0, 0);
        // T4: address wrap
        add(4, 1, 16'hFFFE, 8'd4, 0, 16'h0000, 0, 32'h0,    0, 0);
        add(4, 0, 16'h0,    8'd0, 1, 16'hFFFE, 0, 32'h0,    0, 1);
        add(4, 0, 16'h0,    8'd0, 1, 16'hFFFF, 0, 32'h0,    0, 1);
        add(4, 0, 16'h0,    8'd0, 1, 16'h0000, 1, 32'hFFFE, 0, 1);
        add(4, 0, 16'h0,    8'd0, 1, 16'h0001, 1, 32'hFFFF, 0, 1);
        add(4, 0, 16'h0,    8'd0, 0, 16'h0000, 1, 32'h0000, 0, 1);
        add(4, 0, 16'h0,    8'd0, 0, 16'h0000, 1, 32'h0001, 0, 1);
        add(4, 0, 16'h0,    8'd0, 0, 16'h0000, 0, 32'h0,    1, 1);
        add(4, 0, 16'h0,    8'd0, 0, 16'h0000, 0, 32'h0,    0, 0);

        repeat (2) @(negedge Clock);
        #1;
        check("rst_busy",  {31'd0, oBusy},  32'd0);
        check("rst_done",  {31'd0, oDone},  32'd0);
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_data",  oData,           32'd0);
        check("rst_addr",  {16'd0, oReadAddress}, 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

        foreach (vecs[k]) begin
            @(negedge Clock);
            iStart = vecs[k].start; iBaseAddress = vecs[k].base; iCount = vecs[k].count;
            iReady = 1'b1;
            #1;
            check($sformatf("T%0d_r%0d_re", vecs[k].test, k),    {31'd0, oReadEnable}, {31'd0, vecs[k].re});
            check($sformatf("T%0d_r%0d_valid", vecs[k].test, k), {31'd0, oValid},      {31'd0, vecs[k].valid});
            check($sformatf("T%0d_r%0d_done", vecs[k].test, k),  {31'd0, oDone},       {31'd0, vecs[k].done});
            check($sformatf("T%0d_r%0d_busy", vecs[k].test, k),  {31'd0, oBusy},       {31'd0, vecs[k].busy});
            if (vecs[k].re)
                check($sformatf("T%0d_r%0d_addr", vecs[k].test, k), {16'd0, oReadAddress}, {16'd0, vecs[k].addr});
            if (vecs[k].valid)
                check($sformatf("T%0d_r%0d_data", vecs[k].test, k), oData, vecs[k].data);
        end

        // T3: 8 words at 0x20, iReady low in cycles 3..10
        begin
            int   n0;
            int   c;
            logic got;
            n0 = rx.size(); d0 = dones; a0 = accepted;
            @(negedge Clock);
            iStart = 1'b1; iBaseAddress = 16'h0020; iCount = 8'd8; iReady = 1'b1;
            c = 0;
            got = 1'b0;
            while (c < 60 && !got) begin
                @(negedge Clock);
                c++;
                iStart = 1'b0;
                iReady = !(c >= 3 && c <= 10);
                #1;
                if (c >= 3 && c <= 10) begin
                    check($sformatf("T3_c%0d_outstanding_le2", c),
                          {31'd0, ((issued - a0 - (accepted - a0)) <= 2) ? 1'b1 : 1'b0}, 32'd1);
                    check($sformatf("T3_c%0d_hold_valid", c), {31'd0, oValid}, 32'd1);
                    check($sformatf("T3_c%0d_hold_data", c),  oData, 32'h20);
                end
                if (oDone) got = 1'b1;
            end
            iReady = 1'b1;
            check("T3_done_seen", {31'd0, got}, 32'd1);
            @(negedge Clock);
            #1;
            check("T3_done_count", dones - d0, 32'd1);
            check("T3_word_count", rx.size() - n0, 32'd8);
            for (int i = 0; i < 8; i++) begin
                if (n0 + i < rx.size())
                    check($sformatf("T3_word%0d", i), rx[n0 + i], 32'h20 + i);
            end
        end

        // T5: reset in cycle 3 of an 8-word burst
        @(negedge Clock);
        iStart = 1'b1; iBaseAddress = 16'h0040; iCount = 8'd8; iReady = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        d0 = dones;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("T5_valid", {31'd0, oValid}, 32'd0);
        check("T5_busy",  {31'd0, oBusy},  32'd0);
        check("T5_done",  {31'd0, oDone},  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            #1;
            check($sformatf("T5_discard%0d_valid", i), {31'd0, oValid}, 32'd0);
        end
        check("T5_no_done", dones - d0, 32'd0);
        run_burst("T5_restart", 16'h0050, 8'd2, 1'b0);

        // T6: iStart pulsed every cycle of an active burst
        run_burst("T6", 16'h0060, 8'd6, 1'b1);
        repeat (3) @(negedge Clock);
        #1;
        check("T6_still_idle", {31'd0, oBusy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
